board_rst_seq: RTL and testbench
================================

Name: board_rst_seq

Overview:
Board-level reset and input sequencer that sits between the FPGA pins/clock generator and the sigma SoC instance on NEXYS4_DDR-class boards. It does four things:
- Holds the SoC in reset until the PLL lock is stable, plus a programmable hold time.
- Re-enters reset if lock is lost.
- Debounces the IRQ push-button.
- Synchronises the switch bank.
Its outputs drive sigma's arst_i, irq_btn_i and the switch part of gpio_bi directly.

Parameters:
LOCK_FILTER, 256, consecutive synchronised pll_locked_i=1 cycles required before leaving WAIT_LOCK (>=1)
RST_HOLD_CYCLES, 1024, cycles soc_arst_o stays asserted in HOLD after lock is accepted (>=1)
DEBOUNCE_CYCLES, 800000, cycles the button input must be stable before the debounced level changes (10 ms at 80 MHz)
SW_WIDTH, 16, switch bus width

Ports:
clk_i  input  1  system clock (PLL output)
arst_n_i  input  1  asynchronous reset, active-low (board reset button)
pll_locked_i  input  1  PLL lock flag, asynchronous to clk_i
btn_i  input  1  raw push-button, asynchronous
sw_i  input  SW_WIDTH  raw switches, asynchronous
soc_arst_o  output  1  active-high reset to SoC
irq_btn_o  output  1  debounced button level, gated to 0 unless in RUN
btn_pulse_o  output  1  one-cycle pulse on a debounced rising edge, RUN only
sw_o  output  SW_WIDTH  two-flop synchronised switches
state_o  output  2  current FSM state encoding
lock_lost_o  output  1  sticky flag: lock was lost while in RUN

Behaviour:
- **Async reset.** arst_n_i low asynchronously clears all flops. While reset is active:
  - state = RESET, soc_arst_o = 1;
  - irq_btn_o = 0, btn_pulse_o = 0, sw_o = 0, lock_lost_o = 0, all counters = 0.
- **Reset release.** Synchronous, via a 2-flop reset synchroniser. soc_arst_o is asserted asynchronously and deasserted only synchronously.
- **Input synchronisers.** pll_locked_i, btn_i and each sw_i bit pass through a 2-flop synchroniser. sw_o latency is 2 cycles; no debounce is applied to switches.
- **FSM encoding.** RESET=0, WAIT_LOCK=1, HOLD=2, RUN=3.
- **RESET.** Moves to WAIT_LOCK on the first clock after reset release.
- **WAIT_LOCK.**
  - lock_cnt increments while lock_sync=1 and clears to 0 when lock_sync=0.
  - When lock_cnt reaches LOCK_FILTER-1 with lock_sync=1: go to HOLD, clear hold_cnt.
- **HOLD.**
  - hold_cnt increments each cycle.
  - If lock_sync=0: go to WAIT_LOCK and clear both counters. This has priority over completion.
  - When hold_cnt reaches RST_HOLD_CYCLES-1: go to RUN.
- **RUN.** soc_arst_o = 0; in every other state soc_arst_o = 1.
  - If lock_sync=0: go to WAIT_LOCK and set lock_lost_o = 1 (sticky until arst_n_i).
  - soc_arst_o re-asserts on the same edge the state changes (registered output).
- **Latency with lock already stable.** soc_arst_o falls at edge 1 + 2(sync) + LOCK_FILTER + RST_HOLD_CYCLES after reset release (±1, fixed by the implementation, documented in the testbench).
- **Debouncer.**
  - Counter clears whenever btn_sync equals the debounced state; otherwise it increments.
  - At DEBOUNCE_CYCLES-1 the debounced state flips and the counter clears.
  - The debouncer runs in every FSM state.
- **Button outputs.**
  - irq_btn_o = debounced & (state==RUN).
  - btn_pulse_o is 1 for exactly one cycle on a debounced 0→1 transition occurring while in RUN.
  - Edges outside RUN are dropped, not queued. A button held across entry to RUN gives irq_btn_o=1 but no pulse.
- **Counter widths.** Each counter is $clog2 of its parameter (minimum 1 bit). Counters saturate and never wrap.

Decomposition:
- **Package board_pkg:**
  - state enum (RESET, WAIT_LOCK, HOLD, RUN) with a 2-bit encoding;
  - default constants for LOCK_FILTER, RST_HOLD_CYCLES and DEBOUNCE_CYCLES;
  - a helper for the counter width.
- **Sub-module btn_debounce:** 2-flop synchroniser plus stable-counter, with parameter DEBOUNCE_CYCLES, ports clk_i/arst_n_i/raw_i/level_o/rise_o. Instantiated once; reusable for further buttons.
- **In-line in the top:** the switch synchroniser and the reset synchroniser.

Test Plan:
All scenarios use LOCK_FILTER=4, RST_HOLD_CYCLES=16, DEBOUNCE_CYCLES=8.
1. pll_locked_i=1 from start, release arst_n_i → state_o goes 0→1→2→3; soc_arst_o falls exactly at the computed cycle (≈23 after release), lock_lost_o=0.
2. Lock toggles 1,1,1,0,1,1,1,1 in WAIT_LOCK → filter restarts; HOLD is entered only after 4 consecutive 1s.
3. Drop lock for 1 cycle at hold_cnt=10 → returns to WAIT_LOCK, soc_arst_o stays 1; full 4+16 sequence repeats.
4. In RUN, drop lock → soc_arst_o=1 within 3 cycles (sync + register), lock_lost_o=1 and held through re-lock; cleared only by arst_n_i.
5. In RUN, btn_i bounces 1,0,1,0 then holds 1 for 20 cycles → one btn_pulse_o, irq_btn_o=1 after 2+8 stable cycles; release → irq_btn_o=0 with no pulse.
6. btn_i held 1 throughout reset → irq_btn_o=1 once in RUN, btn_pulse_o never asserts; sw_i=16'hA5C3 → sw_o=16'hA5C3 two cycles later. Assert arst_n_i mid-RUN → soc_arst_o=1 immediately (asynchronously), all outputs at reset values.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and defaults for the board reset/input sequencer.
package board_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int DEF_LOCK_FILTER     = 256;
  localparam int DEF_RST_HOLD_CYCLES = 1024;
  localparam int DEF_DEBOUNCE_CYCLES = 800000;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a stable-time filter
// with a registered rising-edge pulse.
module btn_debounce
  import board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync    <= '0;
      cnt     <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      sync   <= {sync[0], raw_i};
      rise_o <= 1'b0;
      if (sync[1] == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Input differed for the full window: accept the new level.
        level_o <= ~level_o;
        rise_o  <= ~level_o;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_rst_seq.sv
// Board reset sequencer: holds the SoC in reset until PLL lock is stable plus a
// hold time, re-enters reset on lock loss, and conditions the button and switches.
module board_rst_seq
  import board_pkg::*;
#(
  parameter int LOCK_FILTER     = DEF_LOCK_FILTER,
  parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                pll_locked_i,
  input  logic                btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic                soc_arst_o,
  output logic                irq_btn_o,
  output logic                btn_pulse_o,
  output logic [SW_WIDTH-1:0] sw_o,
  output logic [1:0]          state_o,
  output logic                lock_lost_o
);

  localparam int LW = cnt_w(LOCK_FILTER);
  localparam int HW = cnt_w(RST_HOLD_CYCLES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  logic [1:0]          rst_sync;
  logic                core_rst_n;
  logic [1:0]          lock_meta;
  logic                lock_sync;
  logic [SW_WIDTH-1:0] sw_meta;
  state_t              state;
  logic [LW-1:0]       lock_cnt;
  logic [HW-1:0]       hold_cnt;
  logic                btn_level;
  logic                btn_rise;

  // Asserts with arst_n_i, releases two clocks later in the clk_i domain.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign core_rst_n = rst_sync[1];

  always_ff @(posedge clk_i or negedge core_rst_n) begin
    if (!core_rst_n) begin
      lock_meta <= '0;
      sw_meta   <= '0;
      sw_o      <= '0;
    end else begin
      lock_meta <= {lock_meta[0], pll_locked_i};
      sw_meta   <= sw_i;
      sw_o      <= sw_meta;
    end
  end

  assign lock_sync = lock_meta[1];

  // soc_arst_o is updated on the same edge as every state change.
  always_ff @(posedge clk_i or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state       <= ST_RESET;
      soc_arst_o  <= 1'b1;
      lock_lost_o <= 1'b0;
      lock_cnt    <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_WAIT_LOCK;
          lock_cnt <= '0;
        end
        ST_WAIT_LOCK: begin
          if (!lock_sync) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!lock_sync) begin
            state    <= ST_WAIT_LOCK;
            lock_cnt <= '0;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= ST_RUN;
            soc_arst_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_sync) begin
            state       <= ST_WAIT_LOCK;
            soc_arst_o  <= 1'b1;
            lock_lost_o <= 1'b1;
            lock_cnt    <= '0;
          end
        end
        default: begin
          state      <= ST_RESET;
          soc_arst_o <= 1'b1;
        end
      endcase
    end
  end

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i   (clk_i),
    .arst_n_i(core_rst_n),
    .raw_i   (btn_i),
    .level_o (btn_level),
    .rise_o  (btn_rise)
  );

  // Edges seen outside RUN are simply dropped.
  assign irq_btn_o   = btn_level & (state == ST_RUN);
  assign btn_pulse_o = btn_rise & (state == ST_RUN);
  assign state_o     = state;

endmodule

// File: tb/tb_board_rst_seq.sv
// Scoreboard bench for board_rst_seq: a behavioural model predicts every cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_board_rst_seq;

  localparam int LF  = 4;
  localparam int RH  = 16;
  localparam int DB  = 8;
  localparam int SWW = 16;

  logic           clk = 1'b0;
  logic           arst_n;
  logic           pll;
  logic           btn;
  logic [SWW-1:0] sw;
  logic           soc_arst_o, irq_btn_o, btn_pulse_o, lock_lost_o;
  logic [SWW-1:0] sw_o;
  logic [1:0]     state_o;

  always #5 clk = ~clk;

  board_rst_seq #(
    .LOCK_FILTER(LF), .RST_HOLD_CYCLES(RH), .DEBOUNCE_CYCLES(DB), .SW_WIDTH(SWW)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .pll_locked_i(pll), .btn_i(btn), .sw_i(sw),
    .soc_arst_o(soc_arst_o), .irq_btn_o(irq_btn_o), .btn_pulse_o(btn_pulse_o),
    .sw_o(sw_o), .state_o(state_o), .lock_lost_o(lock_lost_o)
  );

  typedef struct packed {
    logic [1:0]     st;
    logic           soc;
    logic           irq;
    logic           pulse;
    logic           lost;
    logic [SWW-1:0] sw;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: phase 0..3 = reset, waiting for lock, hold, run.
  int             m_rel, m_phase, m_ones, m_held, m_run;
  logic           m_lost, m_level, m_rise;
  logic           qlock[$];
  logic           qbtn[$];
  logic [SWW-1:0] qsw[$];

  task automatic model_reset();
    m_rel = 0; m_phase = 0; m_ones = 0; m_held = 0; m_run = 0;
    m_lost = 1'b0; m_level = 1'b0; m_rise = 1'b0;
    qlock = '{1'b0, 1'b0};
    qbtn  = '{1'b0, 1'b0};
    qsw   = '{16'h0, 16'h0};
  endtask

  task automatic model_edge(input logic a, input logic lk, input logic b, input logic [SWW-1:0] s);
    logic l_seen, b_seen;
    exp_t e;
    if (!a) begin
      model_reset();
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      l_seen = qlock.pop_front(); qlock.push_back(lk);
      b_seen = qbtn.pop_front();  qbtn.push_back(b);
      void'(qsw.pop_front());     qsw.push_back(s);
      m_rise = 1'b0;
      if (b_seen == m_level) m_run = 0;
      else begin
        m_run++;
        if (m_run >= DB) begin
          m_level = !m_level;
          m_rise  = m_level;
          m_run   = 0;
        end
      end
      case (m_phase)
        0: begin m_phase = 1; m_ones = 0; end
        1: if (l_seen) begin
             m_ones++;
             if (m_ones >= LF) begin m_phase = 2; m_held = 0; end
           end else m_ones = 0;
        2: if (!l_seen) begin m_phase = 1; m_ones = 0; end
           else begin
             m_held++;
             if (m_held >= RH) m_phase = 3;
           end
        default: if (!l_seen) begin m_phase = 1; m_ones = 0; m_lost = 1'b1; end
      endcase
    end
    e.st    = 2'(m_phase);
    e.soc   = (m_phase != 3);
    e.irq   = m_level && (m_phase == 3);
    e.pulse = m_rise && (m_phase == 3);
    e.lost  = m_lost;
    e.sw    = qsw[0];
    expq.push_back(e);
  endtask

  task automatic step(input logic a, input logic lk, input logic b, input logic [SWW-1:0] s);
    @(negedge clk);
    arst_n = a; pll = lk; btn = b; sw = s;
    model_edge(a, lk, b, s);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one prediction per clock edge.
  int   rel_mon   = 0;
  int   fall_at   = -1;
  int   pulse_cnt = 0;
  logic soc_prev  = 1'b1;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!arst_n) rel_mon = 0;
      else         rel_mon++;
      if (soc_prev && !soc_arst_o) fall_at = rel_mon - 1;
      soc_prev = soc_arst_o;
      if (btn_pulse_o) pulse_cnt++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("state",     32'(state_o),     32'(e.st));
        chk("soc_arst",  32'(soc_arst_o),  32'(e.soc));
        chk("irq_btn",   32'(irq_btn_o),   32'(e.irq));
        chk("btn_pulse", 32'(btn_pulse_o), 32'(e.pulse));
        chk("sw",        32'(sw_o),        32'(e.sw));
        chk("lock_lost", 32'(lock_lost_o), 32'(e.lost));
      end
    end
  end

  initial begin
    logic a, lk, b;
    arst_n = 1'b0; pll = 1'b0; btn = 1'b0; sw = '0;
    model_reset();

    // 1: lock stable from the start. Release is edge 0; the SoC reset drops at
    //    edge 1 (reset sync) + 2 (input sync) + LF + RH = 23.
    repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0);
    fall_at = -1;
    repeat (30) step(1'b1, 1'b1, 1'b0, 16'h1234);
    settle();
    chk("s1_fall_edge", 32'(fall_at), 32'd23);

    // 2: 1,1,1,0 restarts the filter; four ones seen at edges 10..13 -> run at 29.
    repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
    fall_at = -1;
    repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (33) step(1'b1, 1'b1, 1'b0, 16'h00FF);
    settle();
    chk("s2_fall_edge", 32'(fall_at), 32'd29);

    // 3: one-cycle drop seen at edge 18 (hold_cnt=10) -> full 4+16 again, run at 38.
    repeat (2) step(1'b0, 1'b1, 1'b0, 16'h0);
    fall_at = -1;
    repeat (16) step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (30) step(1'b1, 1'b1, 1'b0, 16'h0F0F);
    settle();
    chk("s3_fall_edge", 32'(fall_at), 32'd38);

    // 4: lock loss in run, sticky flag survives relock, cleared only by reset.
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0);
    repeat (40) step(1'b1, 1'b1, 1'b0, 16'h0);
    settle();
    chk("s4_lost_sticky", 32'(lock_lost_o), 32'd1);
    chk("s4_rerun_state", 32'(state_o), 32'd3);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    #1;
    chk("s4_lost_cleared", 32'(lock_lost_o), 32'd0);

    // 5: bounce then a clean press in run gives one pulse; release gives none.
    step(1'b0, 1'b1, 1'b0, 16'h0);
    repeat (30) step(1'b1, 1'b1, 1'b0, 16'h0);
    pulse_cnt = 0;
    step(1'b1, 1'b1, 1'b1, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    repeat (20) step(1'b1, 1'b1, 1'b1, 16'h0);
    settle();
    chk("s5_press_pulses", 32'(pulse_cnt), 32'd1);
    chk("s5_irq_high", 32'(irq_btn_o), 32'd1);
    repeat (20) step(1'b1, 1'b1, 1'b0, 16'h0);
    settle();
    chk("s5_release_pulses", 32'(pulse_cnt), 32'd1);
    chk("s5_irq_low", 32'(irq_btn_o), 32'd0);

    // 6: button held through reset -> level without pulse; then async reset in run.
    pulse_cnt = 0;
    repeat (2) step(1'b0, 1'b1, 1'b1, 16'hA5C3);
    repeat (30) step(1'b1, 1'b1, 1'b1, 16'hA5C3);
    settle();
    chk("s6_irq_held", 32'(irq_btn_o), 32'd1);
    chk("s6_no_pulse", 32'(pulse_cnt), 32'd0);
    chk("s6_sw", 32'(sw_o), 32'hA5C3);
    step(1'b0, 1'b1, 1'b1, 16'hA5C3);
    #1;
    chk("s6_async_soc", 32'(soc_arst_o), 32'd1);
    chk("s6_async_state", 32'(state_o), 32'd0);
    chk("s6_async_irq", 32'(irq_btn_o), 32'd0);
    chk("s6_async_sw", 32'(sw_o), 32'd0);

    // Randomised traffic: rare lock drops and resets, bouncy button, random switches.
    b = 1'b0;
    for (int i = 0; i < 600; i++) begin
      a  = ($urandom_range(0, 299) != 0);
      lk = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) b = ~b;
      step(a, lk, b, 16'($urandom));
    end
    settle();
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
